gr_load_ctrl: RTL and testbench

Load controller for the global render registers (X_center, Y_center, Angle, Zoom). It accepts a 4-byte parameter frame from a byte stream and holds it in shadow registers. It commits all four bytes atomically at the next frame boundary, and only when the renderer is not busy, so the renderer never sees a mix of old and new values. Malformed frames (too short, too long, stalled) are rejected and the committed values are left unchanged.

---
 rtl/gr_load_ctrl.sv | 173 +++++++++++++++++
 tb/tb_gr_load_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gr_load_ctrl.sv
// Global render-register loader: collects a 4-byte frame into shadows and commits it atomically at a frame boundary.
// Latency: the commit condition seen in cycle M gives new outputs and UPDATED at edge M+2, and S_TREADY returns at edge M+3.
// Backpressure: S_TREADY is low while a complete frame waits for its commit, and also during COMMIT and reset.
//
// Ports:
//   ACLK, ARESET                       clock and synchronous active-high reset
//   S_TDATA/S_TVALID/S_TLAST/S_TREADY  byte stream carrying parameter frames
//   FRAME_START, RENDER_BUSY           frame-boundary pulse and renderer-busy commit inhibit
//   X_center, Y_center, Angle, Zoom    committed parameters
//   BC                                 bytes accepted in the current frame (0..4)
//   PARAM_VALID, UPDATED               sticky first-commit flag and per-commit pulse
//   ERR_SHORT, ERR_LONG                one-cycle error pulses for rejected frames
module gr_load_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  X_RST    = 8'h80,
  parameter logic [7:0]  Y_RST    = 8'h80,
  parameter logic [7:0]  ZOOM_RST = 8'h01
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic [7:0] S_TDATA,
  input  logic       S_TVALID,
  input  logic       S_TLAST,
  output logic       S_TREADY,
  input  logic       FRAME_START,
  input  logic       RENDER_BUSY,
  output logic [7:0] X_center,
  output logic [7:0] Y_center,
  output logic [7:0] Angle,
  output logic [7:0] Zoom,
  output logic [3:0] BC,
  output logic       PARAM_VALID,
  output logic       UPDATED,
  output logic       ERR_SHORT,
  output logic       ERR_LONG
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, PENDING, COMMIT} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  shadow [4];
  logic [15:0] tcnt;
  logic        sync_seen;
  logic        tready_q;
  logic        accept;

  logic [3:0]  bc_nxt;
  logic        err_short_nxt, err_long_nxt;
  logic        shadow_we, sync_set, tready_nxt;

  function automatic logic is_rdy(input state_t s);
    return (s == IDLE) || (s == LOAD) || (s == DRAIN);
  endfunction

  // Reset forces the handshake low immediately, even before the first reset edge.
  assign S_TREADY = tready_q & ~ARESET;
  assign accept   = S_TVALID & S_TREADY;

  always_comb begin
    next_state    = state;
    bc_nxt        = BC;
    err_short_nxt = 1'b0;
    err_long_nxt  = 1'b0;
    shadow_we     = 1'b0;
    sync_set      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (S_TLAST) begin
            err_short_nxt = 1'b1;
          end else begin
            bc_nxt     = 4'd1;
            next_state = LOAD;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (BC < 4'd3) begin
            if (S_TLAST) begin
              err_short_nxt = 1'b1;
              bc_nxt        = 4'd0;
              next_state    = IDLE;
            end else begin
              bc_nxt = BC + 4'd1;
            end
          end else begin
            bc_nxt = 4'd4;
            if (S_TLAST) begin
              next_state = PENDING;
            end else begin
              err_long_nxt = 1'b1;
              next_state   = DRAIN;
            end
          end
        end else if (tcnt == TO_LAST) begin
          err_short_nxt = 1'b1;
          bc_nxt        = 4'd0;
          next_state    = IDLE;
        end
      end
      DRAIN: begin
        if (accept && S_TLAST) begin
          bc_nxt     = 4'd0;
          next_state = IDLE;
        end
      end
      PENDING: begin
        // Remember a boundary that arrived while the renderer was busy.
        if (FRAME_START && RENDER_BUSY) sync_set = 1'b1;
        if ((FRAME_START || sync_seen) && !RENDER_BUSY) next_state = COMMIT;
      end
      COMMIT: begin
        bc_nxt     = 4'd0;
        next_state = IDLE;
      end
      default: begin
        bc_nxt     = 4'd0;
        next_state = IDLE;
      end
    endcase
    // Ready only when both the current and the next state accept beats, so
    // entering PENDING closes the handshake at once and the cycle after COMMIT stays closed.
    tready_nxt = is_rdy(state) && is_rdy(next_state);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= IDLE;
      BC          <= 4'd0;
      tcnt        <= 16'd0;
      sync_seen   <= 1'b0;
      tready_q    <= 1'b0;
      X_center    <= X_RST;
      Y_center    <= Y_RST;
      Angle       <= 8'h00;
      Zoom        <= ZOOM_RST;
      PARAM_VALID <= 1'b0;
      UPDATED     <= 1'b0;
      ERR_SHORT   <= 1'b0;
      ERR_LONG    <= 1'b0;
    end else begin
      state     <= next_state;
      BC        <= bc_nxt;
      tready_q  <= tready_nxt;
      ERR_SHORT <= err_short_nxt;
      ERR_LONG  <= err_long_nxt;
      UPDATED   <= (state == COMMIT);
      // Counts idle cycles inside LOAD only; any beat or state change restarts it.
      if (state == LOAD && next_state == LOAD && !accept) tcnt <= tcnt + 16'd1;
      else                                                tcnt <= 16'd0;
      if (state == COMMIT) sync_seen <= 1'b0;
      else if (sync_set)   sync_seen <= 1'b1;
      if (state == COMMIT) begin
        X_center    <= shadow[0];
        Y_center    <= shadow[1];
        Angle       <= shadow[2];
        Zoom        <= shadow[3];
        PARAM_VALID <= 1'b1;
      end
    end
  end

  // Shadows need no reset: they are only observable through a commit.
  always_ff @(posedge ACLK) begin
    if (shadow_we) shadow[BC[1:0]] <= S_TDATA;
  end

endmodule

// File: tb/tb_gr_load_ctrl.sv
// Bench for gr_load_ctrl: table of per-cycle vectors plus directed multi-cycle sequences.
// Latency: inputs are driven 1 time unit after each rising edge, and outputs are checked at that same point.
// Backpressure: the S_TREADY value expected after every edge is part of each check.
module tb_gr_load_ctrl;

  logic       ACLK = 1'b0;
  logic       ARESET;
  logic [7:0] S_TDATA;
  logic       S_TVALID, S_TLAST, S_TREADY;
  logic       FRAME_START, RENDER_BUSY;
  logic [7:0] X_center, Y_center, Angle, Zoom;
  logic [3:0] BC;
  logic       PARAM_VALID, UPDATED, ERR_SHORT, ERR_LONG;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] P0 = 32'h8080_0001;
  localparam logic [31:0] P1 = 32'h1020_3002;
  localparam logic [31:0] P2 = 32'h1122_3344;
  localparam logic [31:0] P3 = 32'h0506_0708;
  localparam logic [31:0] PC = 32'hC1C2_C3C4;

  gr_load_ctrl #(.TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
    .FRAME_START(FRAME_START), .RENDER_BUSY(RENDER_BUSY),
    .X_center(X_center), .Y_center(Y_center), .Angle(Angle), .Zoom(Zoom),
    .BC(BC), .PARAM_VALID(PARAM_VALID), .UPDATED(UPDATED),
    .ERR_SHORT(ERR_SHORT), .ERR_LONG(ERR_LONG)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        vld;
    logic        last;
    logic [7:0]  dat;
    logic        fs;
    logic        busy;
    logic        rdy;
    logic [3:0]  bc;
    logic [31:0] par;
    logic        pv;
    logic        upd;
    logic        es;
    logic        el;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic vld, input logic last, input logic [7:0] dat,
                     input logic fs, input logic busy, input logic rdy,
                     input logic [3:0] bc, input logic [31:0] par, input logic pv,
                     input logic upd, input logic es, input logic el);
    vec_t v;
    v.vld = vld; v.last = last; v.dat = dat; v.fs = fs; v.busy = busy;
    v.rdy = rdy; v.bc = bc; v.par = par; v.pv = pv; v.upd = upd; v.es = es; v.el = el;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    S_TVALID = 1'b0; S_TLAST = 1'b0; S_TDATA = 8'h00;
    FRAME_START = 1'b0; RENDER_BUSY = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    S_TDATA = d; S_TVALID = 1'b1; S_TLAST = last;
    tick();
    S_TVALID = 1'b0; S_TLAST = 1'b0;
  endtask

  function automatic logic [31:0] params();
    return {X_center, Y_center, Angle, Zoom};
  endfunction

  int upd_count;

  initial begin
    idle_inputs();
    ARESET = 1'b1;
    #1;
    chk("rdy_in_reset_pre_edge", 32'(S_TREADY), 32'd0);
    tick();
    tick();
    chk("reset_rdy", 32'(S_TREADY), 32'd0);
    chk("reset_bc", 32'(BC), 32'd0);
    chk("reset_params", params(), P0);
    chk("reset_pv", 32'(PARAM_VALID), 32'd0);
    chk("reset_flags", {29'd0, UPDATED, ERR_SHORT, ERR_LONG}, 32'd0);
    ARESET = 1'b0;

    //   vld last dat  fs busy | rdy bc par pv upd es el
    // Good frame, committed at an idle FRAME_START.
    add(0,0,8'h00,0,0, 1,4'd0,P0,0,0,0,0);
    add(1,0,8'h10,0,0, 1,4'd1,P0,0,0,0,0);
    add(1,0,8'h20,0,0, 1,4'd2,P0,0,0,0,0);
    add(1,0,8'h30,0,0, 1,4'd3,P0,0,0,0,0);
    add(1,1,8'h02,0,0, 0,4'd4,P0,0,0,0,0);
    add(0,0,8'h00,0,0, 0,4'd4,P0,0,0,0,0);
    add(0,0,8'h00,1,0, 0,4'd4,P0,0,0,0,0);
    add(0,0,8'h00,0,0, 0,4'd0,P1,1,1,0,0);
    add(0,0,8'h00,0,0, 1,4'd0,P1,1,0,0,0);
    // Single-byte frame rejected from IDLE.
    add(1,1,8'hEE,0,0, 1,4'd0,P1,1,0,1,0);
    // Two-byte frame rejected, then a good frame.
    add(1,0,8'hAA,0,0, 1,4'd1,P1,1,0,0,0);
    add(1,1,8'hBB,0,0, 1,4'd0,P1,1,0,1,0);
    add(0,0,8'h00,0,0, 1,4'd0,P1,1,0,0,0);
    add(1,0,8'h11,0,0, 1,4'd1,P1,1,0,0,0);
    add(1,0,8'h22,0,0, 1,4'd2,P1,1,0,0,0);
    add(1,0,8'h33,0,0, 1,4'd3,P1,1,0,0,0);
    add(1,1,8'h44,0,0, 0,4'd4,P1,1,0,0,0);
    add(0,0,8'h00,1,0, 0,4'd4,P1,1,0,0,0);
    add(0,0,8'h00,0,0, 0,4'd0,P2,1,1,0,0);
    add(0,0,8'h00,0,0, 1,4'd0,P2,1,0,0,0);
    // FRAME_START coinciding with the 4th byte is ignored; the next one commits.
    add(1,0,8'h05,0,0, 1,4'd1,P2,1,0,0,0);
    add(1,0,8'h06,0,0, 1,4'd2,P2,1,0,0,0);
    add(1,0,8'h07,0,0, 1,4'd3,P2,1,0,0,0);
    add(1,1,8'h08,1,0, 0,4'd4,P2,1,0,0,0);
    add(0,0,8'h00,0,0, 0,4'd4,P2,1,0,0,0);
    add(0,0,8'h00,0,0, 0,4'd4,P2,1,0,0,0);
    add(0,0,8'h00,1,0, 0,4'd4,P2,1,0,0,0);
    add(0,0,8'h00,0,0, 0,4'd0,P3,1,1,0,0);
    add(0,0,8'h00,0,0, 1,4'd0,P3,1,0,0,0);
    // Six-byte frame: ERR_LONG at byte 4, tail drained, no commit.
    add(1,0,8'hA1,0,0, 1,4'd1,P3,1,0,0,0);
    add(1,0,8'hA2,0,0, 1,4'd2,P3,1,0,0,0);
    add(1,0,8'hA3,0,0, 1,4'd3,P3,1,0,0,0);
    add(1,0,8'hA4,0,0, 1,4'd4,P3,1,0,0,1);
    add(1,0,8'hA5,0,0, 1,4'd4,P3,1,0,0,0);
    add(1,1,8'hA6,0,0, 1,4'd0,P3,1,0,0,0);
    add(0,0,8'h00,1,0, 1,4'd0,P3,1,0,0,0);
    add(0,0,8'h00,0,0, 1,4'd0,P3,1,0,0,0);

    foreach (tbl[i]) begin
      S_TVALID = tbl[i].vld; S_TLAST = tbl[i].last; S_TDATA = tbl[i].dat;
      FRAME_START = tbl[i].fs; RENDER_BUSY = tbl[i].busy;
      tick();
      chk($sformatf("row%0d_rdy", i), 32'(S_TREADY), 32'(tbl[i].rdy));
      chk($sformatf("row%0d_bc", i), 32'(BC), 32'(tbl[i].bc));
      chk($sformatf("row%0d_params", i), params(), tbl[i].par);
      chk($sformatf("row%0d_pv", i), 32'(PARAM_VALID), 32'(tbl[i].pv));
      chk($sformatf("row%0d_upd", i), 32'(UPDATED), 32'(tbl[i].upd));
      chk($sformatf("row%0d_err_short", i), 32'(ERR_SHORT), 32'(tbl[i].es));
      chk($sformatf("row%0d_err_long", i), 32'(ERR_LONG), 32'(tbl[i].el));
    end
    idle_inputs();

    // FRAME_START while busy; commit 2 edges after busy drops, exactly once.
    upd_count = 0;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b1);
    chk("busy_pending_bc", 32'(BC), 32'd4);
    RENDER_BUSY = 1'b1; FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    upd_count += int'(UPDATED);
    for (int k = 0; k < 4; k++) begin
      FRAME_START = (k == 2);
      tick();
      upd_count += int'(UPDATED);
      chk($sformatf("busy_hold%0d_params", k), params(), P3);
    end
    FRAME_START = 1'b0; RENDER_BUSY = 1'b0;
    tick();
    upd_count += int'(UPDATED);
    chk("busy_drop_edge1_upd", 32'(UPDATED), 32'd0);
    chk("busy_drop_edge1_params", params(), P3);
    tick();
    upd_count += int'(UPDATED);
    chk("busy_drop_edge2_upd", 32'(UPDATED), 32'd1);
    chk("busy_drop_edge2_params", params(), PC);
    for (int k = 0; k < 4; k++) begin
      tick();
      upd_count += int'(UPDATED);
    end
    chk("busy_single_update", 32'(upd_count), 32'd1);
    chk("busy_rdy_back", 32'(S_TREADY), 32'd1);

    // Timeout: ERR_SHORT on the 8th idle cycle after the last beat.
    send_byte(8'hD1, 1'b0);
    send_byte(8'hD2, 1'b0);
    chk("to_bc_start", 32'(BC), 32'd2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("to_cycle%0d_err_short", k), 32'(ERR_SHORT), (k == 8) ? 32'd1 : 32'd0);
      chk($sformatf("to_cycle%0d_bc", k), 32'(BC), (k == 8) ? 32'd0 : 32'd2);
    end
    tick();
    chk("to_after_err_short", 32'(ERR_SHORT), 32'd0);
    chk("to_after_params", params(), PC);

    // Reset while PENDING discards the frame and restores reset values.
    send_byte(8'hE1, 1'b0);
    send_byte(8'hE2, 1'b0);
    send_byte(8'hE3, 1'b0);
    send_byte(8'hE4, 1'b1);
    tick();
    chk("rst_pending_bc", 32'(BC), 32'd4);
    ARESET = 1'b1;
    #1;
    chk("rst_rdy_comb", 32'(S_TREADY), 32'd0);
    tick();
    tick();
    chk("rst_params", params(), P0);
    chk("rst_pv", 32'(PARAM_VALID), 32'd0);
    chk("rst_bc", 32'(BC), 32'd0);
    chk("rst_rdy", 32'(S_TREADY), 32'd0);
    ARESET = 1'b0;
    tick();
    chk("rst_release_rdy", 32'(S_TREADY), 32'd1);
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    upd_count = int'(UPDATED);
    for (int k = 0; k < 3; k++) begin
      tick();
      upd_count += int'(UPDATED);
    end
    chk("rst_no_update", 32'(upd_count), 32'd0);
    chk("rst_final_params", params(), P0);
    chk("rst_final_pv", 32'(PARAM_VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
